// File: rtl/mxv_mac_sequencer.sv
// mxv_mac_sequencer: streams an MxK signed matrix G against a K-vector E through an external serial MAC, one row per result.
// Latency: first result K+1 cycles after start; K+2 cycles per row while res_ready stays high; M*(K+2) per full pass.
// Backpressure: a result waits in HOLD (MAC held cleared) until res_ready; MXV_SEQ_REF_CHECK_EN adds a shadow accumulator driving err.
module mxv_mac_sequencer #(
  parameter int N = 8,
  parameter int K = 3,
  parameter int M = 3,
  parameter int L = 2*(N-1)+K,
  localparam int RW = (M > 1) ? $clog2(M) : 1,
  localparam int CW = (K > 1) ? $clog2(K) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_en,
  input  logic          ld_sel,
  input  logic [RW-1:0] ld_row,
  input  logic [CW-1:0] ld_col,
  input  logic [N-1:0]  ld_data,
  input  logic          start,
  output logic          busy,
  output logic [N-1:0]  mac_g,
  output logic [N-1:0]  mac_e,
  output logic          mac_rst,
  input  logic [L-1:0]  mac_o,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [L-1:0]  res_data,
  output logic [RW-1:0] res_row,
  output logic          done,
  output logic          err
);

  typedef enum logic [1:0] {IDLE, FEED, CAPTURE, HOLD} state_t;

  state_t        state, state_nxt;
  logic [RW-1:0] m, m_nxt;
  logic [CW-1:0] k, k_nxt;
  logic          hs;
  logic          last_row;
  logic          last_col;
  logic          ld_g_ok;
  logic          ld_e_ok;

  logic [N-1:0]  g_mem [M][K];
  logic [N-1:0]  e_mem [K];

  assign hs       = res_valid && res_ready;
  assign last_row = (m == RW'(M-1));
  assign last_col = (k == CW'(K-1));
  assign busy     = (state != IDLE);

  // Writes land only while idle and only for in-range addresses.
  assign ld_g_ok = ld_en && (state == IDLE) && !ld_sel &&
                   (32'(ld_row) < M) && (32'(ld_col) < K);
  assign ld_e_ok = ld_en && (state == IDLE) && ld_sel && (32'(ld_col) < K);

  // State and row/column counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      m     <= '0;
      k     <= '0;
    end else begin
      state <= state_nxt;
      m     <= m_nxt;
      k     <= k_nxt;
    end
  end

  // Next-state: walk k across a row, capture, then wait for the consumer.
  always_comb begin
    state_nxt = state;
    m_nxt     = m;
    k_nxt     = k;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = FEED;
          m_nxt     = '0;
          k_nxt     = '0;
        end
      end
      FEED: begin
        if (last_col) state_nxt = CAPTURE;
        else          k_nxt     = k + CW'(1);
      end
      CAPTURE: state_nxt = HOLD;
      HOLD: begin
        if (hs) begin
          if (last_row) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = FEED;
            m_nxt     = m + RW'(1);
            k_nxt     = '0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Matrix and vector storage, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < M; i++)
        for (int j = 0; j < K; j++)
          g_mem[i][j] <= '0;
      for (int j = 0; j < K; j++)
        e_mem[j] <= '0;
    end else begin
      if (ld_g_ok) g_mem[ld_row][ld_col] <= ld_data;
      if (ld_e_ok) e_mem[ld_col]         <= ld_data;
    end
  end

  // MAC operands are registered from the next state so they line up with the FEED cycle they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      mac_g   <= '0;
      mac_e   <= '0;
      mac_rst <= 1'b1;
    end else if (state_nxt == FEED) begin
      mac_g   <= g_mem[m_nxt][k_nxt];
      mac_e   <= e_mem[k_nxt];
      mac_rst <= 1'b0;
    end else begin
      mac_g   <= '0;
      mac_e   <= '0;
      mac_rst <= 1'b1;
    end
  end

  // Result register: capture the finished row, drop valid on handshake, pulse done after the last row.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_row   <= '0;
      done      <= 1'b0;
    end else begin
      done <= (state == HOLD) && hs && last_row;
      if (state == CAPTURE) begin
        res_valid <= 1'b1;
        res_data  <= mac_o;
        res_row   <= m;
      end else if (hs) begin
        res_valid <= 1'b0;
      end
    end
  end

`ifdef MXV_SEQ_REF_CHECK_EN
  logic [L-1:0] ref_acc;
  logic [L-1:0] ref_g;
  logic [L-1:0] ref_e;
  logic [L-1:0] ref_prod;

  // Sign-extend straight from storage so a fault on the operand registers is also caught.
  assign ref_g    = {{(L-N){g_mem[m][k][N-1]}}, g_mem[m][k]};
  assign ref_e    = {{(L-N){e_mem[k][N-1]}}, e_mem[k]};
  assign ref_prod = ref_g * ref_e;

  // Shadow accumulator mirrors the MAC contract; a capture-time mismatch latches err.
  always_ff @(posedge clk) begin
    if (rst) begin
      ref_acc <= '0;
      err     <= 1'b0;
    end else begin
      if (state == FEED) ref_acc <= ref_acc + ref_prod;
      else               ref_acc <= '0;
      if ((state == CAPTURE) && (ref_acc != mac_o)) err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mxv_mac_sequencer.sv
// tb_mxv_mac_sequencer: drives mxv_mac_sequencer against a behavioural MAC and dot-product model.
// Latency: checks first result at K+1 and K+2 row spacing with res_ready held high.
// Backpressure: random and fixed res_ready stalls, busy-time load/start noise, mid-pass reset.
`timescale 1ns/1ps
module tb_mxv_mac_sequencer;
  localparam int N  = 8;
  localparam int K  = 3;
  localparam int M  = 3;
  localparam int L  = 2*(N-1)+K;
  localparam int RW = 2;
  localparam int CW = 2;
`ifdef MXV_SEQ_REF_CHECK_EN
  localparam bit REF_EN = 1'b1;
`else
  localparam bit REF_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ld_en = 1'b0;
  logic          ld_sel = 1'b0;
  logic [RW-1:0] ld_row = '0;
  logic [CW-1:0] ld_col = '0;
  logic [N-1:0]  ld_data = '0;
  logic          start = 1'b0;
  logic          res_ready = 1'b0;
  logic          busy, mac_rst, res_valid, done, err;
  logic [N-1:0]  mac_g, mac_e;
  logic [L-1:0]  mac_o, res_data;
  logic [RW-1:0] res_row;

  logic [L-1:0]  acc = '0;
  logic          corrupt = 1'b0;

  int checks = 0;
  int errors = 0;
  int gm [M][K];
  int em [K];

  always #5 clk = ~clk;

  mxv_mac_sequencer dut (
    .clk(clk), .rst(rst), .ld_en(ld_en), .ld_sel(ld_sel), .ld_row(ld_row),
    .ld_col(ld_col), .ld_data(ld_data), .start(start), .busy(busy),
    .mac_g(mac_g), .mac_e(mac_e), .mac_rst(mac_rst), .mac_o(mac_o),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_row(res_row), .done(done), .err(err)
  );

  // Behavioural serial MAC; corrupt offsets only the visible output.
  always @(posedge clk) begin
    if (mac_rst) acc <= '0;
    else         acc <= acc + L'(int'($signed(mac_g)) * int'($signed(mac_e)));
  end
  assign mac_o = acc + L'(corrupt);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [L-1:0] dot(input int r);
    int s;
    s = 0;
    for (int c = 0; c < K; c++) s += gm[r][c] * em[c];
    return s[L-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ld(input bit sel, input int r, input int c, input int v);
    ld_en   = 1'b1;
    ld_sel  = sel;
    ld_row  = r[RW-1:0];
    ld_col  = c[CW-1:0];
    ld_data = v[N-1:0];
    tick();
    ld_en   = 1'b0;
  endtask

  task automatic load_model(input bit skip_last);
    for (int r = 0; r < M; r++)
      for (int c = 0; c < K; c++)
        ld(1'b0, r, c, gm[r][c]);
    for (int c = 0; c < K; c++)
      if (!(skip_last && c == K-1)) ld(1'b1, 0, c, em[c]);
  endtask

  task automatic set_spec();
    gm[0][0] = 29; gm[0][1] = 74;  gm[0][2] = -39;
    gm[1][0] = 67; gm[1][1] = -71; gm[1][2] = 56;
    gm[2][0] = 75; gm[2][1] = -45; gm[2][2] = 34;
    em[0] = -38; em[1] = -91; em[2] = 47;
  endtask

  task automatic set_fill(input int v);
    for (int r = 0; r < M; r++)
      for (int c = 0; c < K; c++)
        gm[r][c] = v;
    for (int c = 0; c < K; c++) em[c] = v;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_busy"},    busy,      0);
    chk({tag, "_mac_rst"}, mac_rst,   1);
    chk({tag, "_mac_g"},   mac_g,     0);
    chk({tag, "_mac_e"},   mac_e,     0);
    chk({tag, "_valid"},   res_valid, 0);
    chk({tag, "_data"},    res_data,  0);
    chk({tag, "_row"},     res_row,   0);
    chk({tag, "_done"},    done,      0);
    chk({tag, "_err"},     err,       0);
  endtask

  // mode 0: ready high, 1: random ready, 2: 7-cycle stall on row 1, 3: random ready plus busy-time load/start noise
  task automatic run_pass(input int mode, input bit bad2, input bit ld_with_start, input string tag);
    int j, rows, stall, dones;
    bit prev_v;
    logic [L-1:0] prev_d, exp_d;
    logic [RW-1:0] prev_r;
    logic [N-1:0] eg, ee;
    j = 0; rows = 0; stall = 0; dones = 0; prev_v = 1'b0;
    prev_d = '0; prev_r = '0;
    start = 1'b1;
    res_ready = (mode == 0);
    if (ld_with_start) begin
      ld_en = 1'b1; ld_sel = 1'b1; ld_col = CW'(K-1); ld_data = em[K-1][N-1:0];
    end
    tick();
    start = 1'b0;
    ld_en = 1'b0;
    eg = gm[0][0][N-1:0];
    ee = em[0][N-1:0];
    chk({tag, "_busy"},     busy,    1);
    chk({tag, "_feed_rst"}, mac_rst, 0);
    chk({tag, "_feed_g"},   mac_g,   eg);
    chk({tag, "_feed_e"},   mac_e,   ee);
    while (rows < M && j < 400) begin
      if (mode == 3) begin
        ld_en   = 1'($urandom_range(0, 1));
        ld_sel  = 1'($urandom_range(0, 1));
        ld_row  = RW'($urandom_range(0, M-1));
        ld_col  = CW'($urandom_range(0, K-1));
        ld_data = N'($urandom);
        start   = 1'b1;
      end
      if (res_valid) begin
        if (mode == 2) chk({tag, "_hold_clr"}, mac_rst, 1);
        if (prev_v) begin
          if (mode == 2) begin
            chk({tag, "_stable_d"}, res_data, prev_d);
            chk({tag, "_stable_r"}, res_row,  prev_r);
          end
        end else if (mode == 0) begin
          chk({tag, "_lat"}, j, K+1+rows*(K+2));
        end
      end
      if (mode == 0) res_ready = 1'b1;
      else if (mode == 2) begin
        if (rows == 1 && res_valid && stall < 7) begin
          res_ready = 1'b0;
          stall++;
        end else res_ready = 1'b1;
      end else res_ready = 1'($urandom_range(0, 1));
      if (done) dones++;
      if (res_valid && res_ready) begin
        exp_d = dot(rows);
        if (bad2 && rows == 2) exp_d = exp_d + L'(1);
        chk({tag, "_data"}, res_data, exp_d);
        chk({tag, "_row"},  res_row,  rows);
        chk({tag, "_err"},  err,      (REF_EN && bad2 && rows == 2) ? 1 : 0);
        rows++;
        prev_v = 1'b0;
      end else prev_v = res_valid;
      prev_d = res_data;
      prev_r = res_row;
      corrupt = bad2 && (rows == 2);
      tick();
      j++;
    end
    ld_en = 1'b0;
    start = 1'b0;
    corrupt = 1'b0;
    chk({tag, "_rows"},       rows,  M);
    chk({tag, "_early_done"}, dones, 0);
    chk({tag, "_done"},       done,  1);
    chk({tag, "_idle"},       busy,  0);
    if (mode == 2) chk({tag, "_stall_len"}, stall, 7);
    res_ready = 1'b0;
    tick();
    chk({tag, "_done_off"}, done, 0);
  endtask

  initial begin
    bit any_v;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    reset_checks("rst");

    set_spec();
    load_model(1'b0);
    run_pass(0, 1'b0, 1'b0, "spec");

    set_fill(-128);
    load_model(1'b0);
    run_pass(0, 1'b0, 1'b0, "neg");

    set_spec();
    load_model(1'b0);
    run_pass(2, 1'b0, 1'b0, "stall");
    run_pass(3, 1'b0, 1'b0, "noise");
    run_pass(0, 1'b0, 1'b0, "post_noise");

    for (int it = 0; it < 6; it++) begin
      for (int r = 0; r < M; r++)
        for (int c = 0; c < K; c++)
          gm[r][c] = int'($urandom_range(0, 255)) - 128;
      for (int c = 0; c < K; c++) em[c] = int'($urandom_range(0, 255)) - 128;
      load_model(it[0]);
      ld(1'b0, 3, 0, int'($urandom));
      ld(1'b0, 0, 3, int'($urandom));
      ld(1'b1, 0, 3, int'($urandom));
      run_pass(1, 1'b0, it[0], "rand");
    end

    set_spec();
    load_model(1'b0);
    start = 1'b1;
    res_ready = 1'b1;
    tick();
    start = 1'b0;
    repeat (K+2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    reset_checks("midrst");
    any_v = 1'b0;
    repeat (10) begin
      if (res_valid) any_v = 1'b1;
      tick();
    end
    chk("midrst_no_valid", any_v, 0);
    res_ready = 1'b0;
    set_fill(0);
    run_pass(0, 1'b0, 1'b0, "cleared");
    set_spec();
    load_model(1'b0);
    run_pass(0, 1'b0, 1'b0, "reload");

`ifdef MXV_SEQ_REF_CHECK_EN
    run_pass(0, 1'b1, 1'b0, "ref");
    chk("ref_err_set", err, 1);
    repeat (5) tick();
    chk("ref_err_sticky", err, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("ref_err_clr", err, 0);
`else
    chk("err_tied", err, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mxv_mac_sequencer.md
# mxv_mac_sequencer

Initiator for the serial signed MAC (`mac_nnbit_kcc` contract). It holds an M×K signed matrix G and a K-element vector E in local registers. On `start` it streams one row at a time into the MAC as element pairs, clears the MAC between rows, and captures each row's accumulated dot product. Results leave through a valid/ready port, so the hardware performs the matrix×vector computation that previously existed only as bench stimulus.

## Interface
- `N`, 8, signed element width of G and E
- `K`, 3, vector dimension (pairs per row)
- `M`, 3, matrix rows
- `L`, 2*(N-1)+K, accumulator/result width
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `ld_en`  in  1  load strobe
- `ld_sel`  in  1  0 = write G[ld_row][ld_col], 1 = write E[ld_col]
- `ld_row`  in  max(1,$clog2(M))  row address
- `ld_col`  in  max(1,$clog2(K))  column address
- `ld_data`  in  N  signed element
- `start`  in  1  begin a full M-row pass
- `busy`  out  1  high in any state other than IDLE
- `mac_g`  out  N  MAC g operand (registered)
- `mac_e`  out  N  MAC e operand (registered)
- `mac_rst`  out  1  MAC clear (registered)
- `mac_o`  in  L  MAC accumulator output
- `res_valid`  out  1  result available
- `res_ready`  in  1  consumer accepts result
- `res_data`  out  L  signed dot product of the current row
- `res_row`  out  max(1,$clog2(M))  row index of `res_data`
- `done`  out  1  one-cycle pulse after the last row is accepted
- `err`  out  1  sticky reference mismatch (see Configuration)

## Operation
- MAC contract: at each clk edge, if `mac_rst` then acc←0, else acc←acc+g·e (signed, wraps mod 2^L). `mac_o` = acc.
- Loads are accepted only in IDLE. Loads while `busy` are ignored. Out-of-range row or column addresses are ignored. A load and `start` in the same IDLE cycle are both accepted.
- States:
  - IDLE: `start` moves to FEED with m=0, k=0.
  - FEED: k=0..K-1, then CAPTURE.
  - CAPTURE: moves to HOLD.
  - HOLD: on `res_valid`&&`res_ready`, m<M-1 moves to FEED with m+1, k=0; m=M-1 moves to IDLE and pulses `done`.
- `start` is ignored while `busy`.
- In FEED, `mac_g`=G[m][k], `mac_e`=E[k], `mac_rst`=0. In all other states, `mac_g`=`mac_e`=0 and `mac_rst`=1, which guarantees a clear of at least 2 cycles between rows.
- CAPTURE edge: `res_data`←`mac_o`, `res_row`←m, `res_valid`←1.
- `res_data` and `res_row` stay stable while `res_valid` is high and `res_ready` is low.
- Reset values: state IDLE, `busy`=0, `mac_g`=`mac_e`=0, `mac_rst`=1, `res_valid`=0, `res_data`=0, `res_row`=0, `done`=0, `err`=0. G and E storage clears to 0.
- `rst` mid-pass aborts immediately to reset values. No partial result is emitted.

## Timing
- `start` sampled at edge e0 → first FEED cycle follows e0 → MAC adds at edges e0+1..e0+K → `res_valid` rises after edge e0+K+1 (latency K+1; 4 for K=3).
- With `res_ready` held high, the row period is K+2 cycles; a full pass is M·(K+2) cycles.
- `done` is high for exactly the one cycle following the final handshake edge.
- Backpressure stalls only in HOLD. The MAC stays cleared during the stall.

## Configuration
- `MXV_SEQ_REF_CHECK_EN` defined:
  - An internal reference accumulator (L bits) clears outside FEED and adds sign-extended G[m][k]·E[k] each FEED cycle.
  - At the CAPTURE edge, if it differs from `mac_o`, `err`←1.
  - `err` stays set until `rst`.
- Macro undefined: no reference logic is built and `err` is tied to 0.

## Test plan
- Load G={{29,74,-39},{67,-71,56},{75,-45,34}}, E={-38,-91,47}, pulse `start`, hold `res_ready`=1 → `res_data` -9669, 6547, 2843 with `res_row` 0,1,2. First `res_valid` 4 cycles after the start edge, then every 5 cycles. `done` pulses once. `err`=0.
- All elements -128 → each row yields 49152 with no overflow in 17 bits.
- Hold `res_ready`=0 for 7 cycles on row 1 → `res_data`=6547 held stable, `mac_rst`=1 throughout the stall, row 2 still yields 2843.
- Assert `ld_en` and `start` while `busy` → storage unchanged, pass unaffected, results identical to the first scenario.
- Assert `rst` during the row-1 FEED → next cycle all outputs are at reset values and `res_valid` stays 0. A subsequent reload and start reproduces the first scenario.
- With `MXV_SEQ_REF_CHECK_EN` defined and the bench MAC model corrupting row 2 by +1 → `err` rises after the row-2 CAPTURE edge and stays high until `rst`.
